dma_master: RTL

AXI master copy engine driven by the DMA configuration slave's DMAEN/DMASRC/DMADST/DMALEN outputs.
- When enabled, it reads DMALEN 32-bit words from DMASRC and writes them to DMADST.
- The copy is split into INCR bursts, each staged through an internal burst buffer.
- It sits on a master port of the AXI bus. It raises a done interrupt to the CPU.

---
 rtl/dma_master_pkg.sv | 34 +++
 rtl/dma_burst_buf.sv | 33 +++
 rtl/dma_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_master_pkg.sv
// Shared AXI constants and the DMA state encoding used by the DMA master.
// Provides:
//   ADDR_W / DATA_W    bus widths
//   AXI_SIZE_WORD      AxSIZE for 32-bit beats
//   AXI_BURST_INCR     AxBURST incrementing
//   AXI_RESP_OKAY      xRESP success code
//   dma_state_t        copy-engine state machine states
//   words_to_page()    words left before the next 4KB boundary
package dma_master_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int PAGE_WORDS = 1024;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP,
    DONE
  } dma_state_t;

  // AXI bursts may not cross a 4KB page; word_off is addr[11:2].
  function automatic logic [31:0] words_to_page(input logic [9:0] word_off);
    return 32'(PAGE_WORDS) - 32'(word_off);
  endfunction

endpackage

// File: rtl/dma_burst_buf.sv
// Burst staging buffer: holds one read burst until it is written back out.
// Ports:
//   clk      clock
//   wr_idx   write index (read-data beat number)
//   wr_data  word to store
//   wr_en    store strobe
//   rd_idx   read index (write-data beat number)
//   rd_data  combinational read of entry rd_idx
module dma_burst_buf
  import dma_master_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Data storage needs no reset; entries a short read burst never fills are
  // deliberately written out as whatever they last held.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dma_master.sv
// AXI master copy engine. When DMAEN is seen it copies DMALEN words from
// DMASRC to DMADST as a sequence of INCR read-burst / write-burst pairs, each
// burst staged through dma_burst_buf, then raises DMA_done until DMAEN drops.
// Ports:
//   clk, rst                      clock, async active-low reset
//   DMAEN/DMASRC/DMADST/DMALEN    job request from the configuration slave
//   M_AR* / M_R*                  AXI read address / read data channels
//   M_AW* / M_W* / M_B*           AXI write address / data / response channels
//   DMA_done                      completion interrupt (level)
//   DMA_err                       sticky error flag for the current job
module dma_master
  import dma_master_pkg::*;
#(
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] MST_ID    = '0,
  parameter int              BURST_MAX = 16,
  parameter int              LEN_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DMAEN,
  input  logic [ADDR_W-1:0] DMASRC,
  input  logic [ADDR_W-1:0] DMADST,
  input  logic [31:0]       DMALEN,
  output logic [ID_W-1:0]   M_ARID,
  output logic [ADDR_W-1:0] M_ARAddr,
  output logic [LEN_W-1:0]  M_ARLen,
  output logic [2:0]        M_ARSize,
  output logic [1:0]        M_ARBurst,
  output logic              M_ARValid,
  input  logic              M_ARReady,
  input  logic [ID_W-1:0]   M_RID,
  input  logic [DATA_W-1:0] M_RData,
  input  logic [1:0]        M_RResp,
  input  logic              M_RLast,
  input  logic              M_RValid,
  output logic              M_RReady,
  output logic [ID_W-1:0]   M_AWID,
  output logic [ADDR_W-1:0] M_AWAddr,
  output logic [LEN_W-1:0]  M_AWLen,
  output logic [2:0]        M_AWSize,
  output logic [1:0]        M_AWBurst,
  output logic              M_AWValid,
  input  logic              M_AWReady,
  output logic [DATA_W-1:0] M_WData,
  output logic [3:0]        M_WStrb,
  output logic              M_WLast,
  output logic              M_WValid,
  input  logic              M_WReady,
  input  logic [ID_W-1:0]   M_BID,
  input  logic [1:0]        M_BResp,
  input  logic              M_BValid,
  output logic              M_BReady,
  output logic              DMA_done,
  output logic              DMA_err
);

  localparam int BW = LEN_W + 1;

  dma_state_t        state, state_nxt;
  logic [ADDR_W-1:0] src, dst, src_adv, dst_adv;
  logic [31:0]       remaining, rem_adv, rem_calc, beats_calc;
  logic [9:0]        src_off, dst_off;
  logic [BW-1:0]     beats, beats_m1;
  logic [LEN_W-1:0]  beat_cnt, wbeat;
  logic              err, r_fire, rbeat_last, wbeat_last;
  logic              unused_ids;

  // Only one transaction is ever outstanding, so returned IDs carry no info.
  assign unused_ids = ^{M_RID, M_BID};

  assign beats_m1   = beats - BW'(1);
  assign rbeat_last = ({1'b0, beat_cnt} == beats_m1);
  assign wbeat_last = ({1'b0, wbeat} == beats_m1);
  assign r_fire     = M_RValid & M_RReady;

  assign src_adv = src + (32'(beats) << 2);
  assign dst_adv = dst + (32'(beats) << 2);
  assign rem_adv = remaining - 32'(beats);

  assign M_ARID    = MST_ID;
  assign M_ARAddr  = src;
  assign M_ARLen   = LEN_W'(beats_m1);
  assign M_ARSize  = AXI_SIZE_WORD;
  assign M_ARBurst = AXI_BURST_INCR;
  assign M_AWID    = MST_ID;
  assign M_AWAddr  = dst;
  assign M_AWLen   = LEN_W'(beats_m1);
  assign M_AWSize  = AXI_SIZE_WORD;
  assign M_AWBurst = AXI_BURST_INCR;
  assign M_WStrb   = 4'hF;
  assign M_WLast   = (state == WDATA) && wbeat_last;
  assign DMA_done  = (state == DONE);
  assign DMA_err   = err;

  // Burst size for the burst about to start. It is evaluated on the cycle
  // that enters RADDR, so it must look at the values src/dst/remaining are
  // about to take: the job request when leaving IDLE, the advanced pointers
  // when leaving WRESP.
  always_comb begin
    src_off  = src_adv[11:2];
    dst_off  = dst_adv[11:2];
    rem_calc = rem_adv;
    if (state == IDLE) begin
      src_off  = DMASRC[11:2];
      dst_off  = DMADST[11:2];
      rem_calc = DMALEN;
    end
    beats_calc = rem_calc;
    if (beats_calc > 32'(BURST_MAX))        beats_calc = 32'(BURST_MAX);
    if (beats_calc > words_to_page(src_off)) beats_calc = words_to_page(src_off);
    if (beats_calc > words_to_page(dst_off)) beats_calc = words_to_page(dst_off);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Read and write phases are strictly sequential; each channel's handshake
  // signal is simply "we are in that channel's state".
  always_comb begin
    state_nxt = state;
    M_ARValid = 1'b0;
    M_RReady  = 1'b0;
    M_AWValid = 1'b0;
    M_WValid  = 1'b0;
    M_BReady  = 1'b0;
    case (state)
      IDLE:  if (DMAEN) state_nxt = (DMALEN == '0) ? DONE : RADDR;
      RADDR: begin
        M_ARValid = 1'b1;
        if (M_ARReady) state_nxt = RDATA;
      end
      RDATA: begin
        M_RReady = 1'b1;
        if (M_RValid && (M_RLast || rbeat_last)) state_nxt = WADDR;
      end
      WADDR: begin
        M_AWValid = 1'b1;
        if (M_AWReady) state_nxt = WDATA;
      end
      WDATA: begin
        M_WValid = 1'b1;
        if (M_WReady && wbeat_last) state_nxt = WRESP;
      end
      WRESP: begin
        M_BReady = 1'b1;
        if (M_BValid) state_nxt = (rem_adv == '0) ? DONE : RADDR;
      end
      DONE:    if (!DMAEN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, beat counters and the sticky error flag. Bad responses and a
  // short read burst flag the job but never stop it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      beats     <= '0;
      beat_cnt  <= '0;
      wbeat     <= '0;
      err       <= 1'b0;
    end else begin
      if (state != RADDR && state_nxt == RADDR) beats <= BW'(beats_calc);
      case (state)
        IDLE: if (DMAEN) begin
          src       <= DMASRC;
          dst       <= DMADST;
          remaining <= DMALEN;
          err       <= 1'b0;
        end
        RADDR: beat_cnt <= '0;
        RDATA: if (r_fire) begin
          beat_cnt <= beat_cnt + LEN_W'(1);
          if (M_RResp != AXI_RESP_OKAY || (M_RLast && !rbeat_last)) err <= 1'b1;
        end
        WADDR: wbeat <= '0;
        WDATA: if (M_WValid && M_WReady) wbeat <= wbeat + LEN_W'(1);
        WRESP: if (M_BValid) begin
          src       <= src_adv;
          dst       <= dst_adv;
          remaining <= rem_adv;
          if (M_BResp != AXI_RESP_OKAY) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  dma_burst_buf #(
    .DEPTH (BURST_MAX),
    .IDX_W (LEN_W)
  ) u_buf (
    .clk     (clk),
    .wr_idx  (beat_cnt),
    .wr_data (M_RData),
    .wr_en   (r_fire),
    .rd_idx  (wbeat),
    .rd_data (M_WData)
  );

endmodule
